shift_add_mult_seq: RTL

- Multi-cycle unsigned multiplier controller that sequences a single WIDTH-bit ripple adder datapath. It uses shift-and-add: one conditional add plus one right shift per cycle.
- Replaces a combinational array multiplier where area matters.
- Uses a start/busy/done handshake so a host FSM or testbench can issue back-to-back multiplies.

---
 rtl/shift_add_mult_seq_if.sv | 23 ++
 rtl/shift_add_mult_seq.sv | 86 ++++++++
 2 files changed

// File: rtl/shift_add_mult_seq_if.sv
// Host-side bundle for the sequential multiplier: start/abort request, operands, and busy/done/product status.
// The host drives the request signals; the multiplier drives the status signals.
interface shift_add_mult_seq_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic                 abort;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, abort, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, abort, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/shift_add_mult_seq.sv
// Shift-and-add unsigned multiplier: one conditional add and one right shift per cycle, WIDTH+2 cycles per product.
// No backpressure: start is only sampled in IDLE, abort cancels an in-flight multiply.
module shift_add_mult_seq #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  shift_add_mult_seq_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH:0]     p_q, p_d, p_next;
  logic [WIDTH:0]       addend;
  logic [WIDTH:0]       sum;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  // Upper half accumulates; lower half holds the remaining multiplier bits and
  // fills with product bits as it shifts right.
  always_comb begin
    addend = p_q[0] ? {1'b0, mcand_q} : '0;
    sum    = p_q[2*WIDTH:WIDTH] + addend;
    p_next = {1'b0, sum, p_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    p_d       = p_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          mcand_d = bus.a;
          p_d     = {{(WIDTH+1){1'b0}}, bus.b};
          count_d = CW'(WIDTH - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          p_d = p_next;
          if (count_q == '0) begin
            product_d = p_next[2*WIDTH-1:0];
            state_d   = DONE;
          end else begin
            count_d = count_q - CW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      p_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      p_q       <= p_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign bus.busy    = (state_q == CALC) || (state_q == DONE);
  assign bus.done    = (state_q == DONE);
  assign bus.product = product_q;
endmodule
